// File: rtl/bram_write_arbiter.sv
// Round-robin arbiter sharing one BRAM write port between two requesters,
// each writing sequential words into its own fixed address region.
module bram_write_arbiter #(
  parameter int                    DATA_WIDTH   = 32,
  parameter int                    ADDR_WIDTH   = 32,
  parameter logic [ADDR_WIDTH-1:0] BASE_ADDR_0  = 32'hB002_0000,
  parameter logic [ADDR_WIDTH-1:0] BASE_ADDR_1  = 32'hB003_0000,
  parameter int                    REGION_WORDS = 1024
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [1:0]              req_valid,
  input  logic [2*DATA_WIDTH-1:0] req_data,
  input  logic [1:0]              req_last,
  output logic [1:0]              req_ready,
  input  logic                    clear_overflow,
  output logic [ADDR_WIDTH-1:0]   bram_addr,
  output logic [DATA_WIDTH-1:0]   bram_data,
  output logic [3:0]              write_enable,
  output logic [1:0]              overflow,
  output logic                    busy
);

  localparam int OFF_W = $clog2(REGION_WORDS);
  localparam logic [OFF_W-1:0] OFF_MAX = OFF_W'(REGION_WORDS - 1);

  // Handshake: a word moves when req_valid[i] && req_ready[i]; at most one
  // ready bit is high, and ready never depends on req_data or req_last.
  typedef enum logic {PRIO0, PRIO1} state_t;

  state_t                  state, state_next;
  logic [1:0]              grant;
  logic [OFF_W-1:0]        off [2];
  logic [OFF_W-1:0]        off_next [2];
  logic [1:0]              wrap;
  logic [ADDR_WIDTH-1:0]   addr_next;
  logic [DATA_WIDTH-1:0]   data_next;

  function automatic logic [ADDR_WIDTH-1:0] word_to_byte(input logic [OFF_W-1:0] o);
    return {{(ADDR_WIDTH-OFF_W-2){1'b0}}, o, 2'b00};
  endfunction

  always_comb begin
    grant      = 2'b00;
    state_next = state;
    if (reset) begin
      case (req_valid)
        2'b01:   grant = 2'b01;
        2'b10:   grant = 2'b10;
        2'b11:   grant = (state == PRIO0) ? 2'b01 : 2'b10;
        default: grant = 2'b00;
      endcase
    end
    if (grant[0])      state_next = PRIO1;
    else if (grant[1]) state_next = PRIO0;
  end

  assign req_ready = grant;

  // A non-last word at the top of the region wraps to zero and flags overflow.
  always_comb begin
    wrap = 2'b00;
    for (int i = 0; i < 2; i++) begin
      off_next[i] = off[i];
      if (grant[i]) begin
        if (req_last[i]) begin
          off_next[i] = '0;
        end else if (off[i] == OFF_MAX) begin
          off_next[i] = '0;
          wrap[i]     = 1'b1;
        end else begin
          off_next[i] = off[i] + OFF_W'(1);
        end
      end
    end
  end

  always_comb begin
    if (grant[1]) begin
      addr_next = BASE_ADDR_1 + word_to_byte(off[1]);
      data_next = req_data[DATA_WIDTH +: DATA_WIDTH];
    end else begin
      addr_next = BASE_ADDR_0 + word_to_byte(off[0]);
      data_next = req_data[0 +: DATA_WIDTH];
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state        <= PRIO0;
      off[0]       <= '0;
      off[1]       <= '0;
      bram_addr    <= BASE_ADDR_0;
      bram_data    <= '0;
      write_enable <= 4'b0000;
      overflow     <= 2'b00;
    end else begin
      state        <= state_next;
      off[0]       <= off_next[0];
      off[1]       <= off_next[1];
      write_enable <= (|grant) ? 4'b1111 : 4'b0000;
      if (|grant) begin
        bram_addr <= addr_next;
        bram_data <= data_next;
      end
      // A wrap in the same cycle as a clear keeps the bit set.
      overflow <= wrap | (clear_overflow ? 2'b00 : overflow);
    end
  end

  assign busy = (off[0] != '0) || (off[1] != '0) || (|write_enable);

endmodule

// File: tb/tb_bram_write_arbiter.sv
// Directed bench for bram_write_arbiter: a per-cycle vector table plus
// hand-written sequences for reset, region wrap/overflow and reset mid-job.
module tb_bram_write_arbiter;

  logic        clk = 1'b0;
  logic        reset;
  logic [1:0]  req_valid;
  logic [63:0] req_data;
  logic [1:0]  req_last;
  logic        clear_overflow;

  logic [1:0]  req_ready,    w_req_ready;
  logic [31:0] bram_addr,    w_bram_addr;
  logic [31:0] bram_data,    w_bram_data;
  logic [3:0]  write_enable, w_write_enable;
  logic [1:0]  overflow,     w_overflow;
  logic        busy,         w_busy;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  bram_write_arbiter dut (
    .clk(clk), .reset(reset), .req_valid(req_valid), .req_data(req_data),
    .req_last(req_last), .req_ready(req_ready), .clear_overflow(clear_overflow),
    .bram_addr(bram_addr), .bram_data(bram_data), .write_enable(write_enable),
    .overflow(overflow), .busy(busy)
  );

  bram_write_arbiter #(.REGION_WORDS(4)) dut_w (
    .clk(clk), .reset(reset), .req_valid(req_valid), .req_data(req_data),
    .req_last(req_last), .req_ready(w_req_ready), .clear_overflow(clear_overflow),
    .bram_addr(w_bram_addr), .bram_data(w_bram_data), .write_enable(w_write_enable),
    .overflow(w_overflow), .busy(w_busy)
  );

  typedef struct {
    logic [1:0]  valid;
    logic [1:0]  last;
    logic [31:0] d0;
    logic [31:0] d1;
    logic [1:0]  ready;
    logic        we;
    logic [31:0] addr;
    logic [31:0] data;
    logic        busy;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(logic [1:0] v, logic [1:0] l, logic [31:0] d0, logic [31:0] d1,
                              logic [1:0] r, logic we, logic [31:0] a, logic [31:0] d, logic b);
    vec_t t;
    t.valid = v; t.last = l; t.d0 = d0; t.d1 = d1;
    t.ready = r; t.we = we; t.addr = a; t.data = d; t.busy = b;
    return t;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Drive one cycle of inputs and advance to just after the next rising edge.
  task automatic drive(input logic [1:0] v, input logic [1:0] l, input logic [31:0] d0,
                       input logic [31:0] d1, input logic clr);
    req_valid      = v;
    req_last       = l;
    req_data       = {d1, d0};
    clear_overflow = clr;
    @(posedge clk);
    #1;
  endtask

  initial begin
    reset = 1'b0; req_valid = 2'b11; req_last = 2'b00;
    req_data = '0; clear_overflow = 1'b0;

    // Reset held with both requesters asking.
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_ready", {30'd0, req_ready}, 32'h0);
    check("rst_we", {28'd0, write_enable}, 32'h0);
    check("rst_addr", bram_addr, 32'hB002_0000);
    check("rst_data", bram_data, 32'h0);
    check("rst_ovf", {30'd0, overflow}, 32'h0);
    check("rst_busy", {31'd0, busy}, 32'h0);
    @(posedge clk);
    #1;
    reset = 1'b1;

    // Contention from reset, then flush both jobs with last.
    vecs.push_back(mk(2'b11, 2'b00, 32'hA0, 32'hB0, 2'b01, 1, 32'hB002_0000, 32'hA0, 1));
    vecs.push_back(mk(2'b11, 2'b00, 32'hA1, 32'hB0, 2'b10, 1, 32'hB003_0000, 32'hB0, 1));
    vecs.push_back(mk(2'b11, 2'b00, 32'hA1, 32'hB1, 2'b01, 1, 32'hB002_0004, 32'hA1, 1));
    vecs.push_back(mk(2'b11, 2'b00, 32'hA2, 32'hB1, 2'b10, 1, 32'hB003_0004, 32'hB1, 1));
    vecs.push_back(mk(2'b11, 2'b00, 32'hA2, 32'hB2, 2'b01, 1, 32'hB002_0008, 32'hA2, 1));
    vecs.push_back(mk(2'b11, 2'b00, 32'hA3, 32'hB2, 2'b10, 1, 32'hB003_0008, 32'hB2, 1));
    vecs.push_back(mk(2'b01, 2'b01, 32'hA3, 32'hB3, 2'b01, 1, 32'hB002_000C, 32'hA3, 1));
    vecs.push_back(mk(2'b10, 2'b10, 32'hA3, 32'hB3, 2'b10, 1, 32'hB003_000C, 32'hB3, 1));
    vecs.push_back(mk(2'b00, 2'b00, 32'h0,  32'h0,  2'b00, 0, 32'hB003_000C, 32'hB3, 0));
    // Single stream from requester 0, then a fresh job restarting at the base.
    vecs.push_back(mk(2'b01, 2'b00, 32'h11, 32'h0, 2'b01, 1, 32'hB002_0000, 32'h11, 1));
    vecs.push_back(mk(2'b01, 2'b00, 32'h22, 32'h0, 2'b01, 1, 32'hB002_0004, 32'h22, 1));
    vecs.push_back(mk(2'b01, 2'b00, 32'h33, 32'h0, 2'b01, 1, 32'hB002_0008, 32'h33, 1));
    vecs.push_back(mk(2'b01, 2'b01, 32'h44, 32'h0, 2'b01, 1, 32'hB002_000C, 32'h44, 1));
    vecs.push_back(mk(2'b01, 2'b00, 32'h55, 32'h0, 2'b01, 1, 32'hB002_0000, 32'h55, 1));
    vecs.push_back(mk(2'b01, 2'b01, 32'h66, 32'h0, 2'b01, 1, 32'hB002_0004, 32'h66, 1));
    vecs.push_back(mk(2'b00, 2'b00, 32'h0,  32'h0, 2'b00, 0, 32'hB002_0004, 32'h66, 0));
    // Requester 1 alone, then a tie must go to requester 0.
    vecs.push_back(mk(2'b10, 2'b00, 32'h0, 32'h77, 2'b10, 1, 32'hB003_0000, 32'h77, 1));
    vecs.push_back(mk(2'b10, 2'b00, 32'h0, 32'h88, 2'b10, 1, 32'hB003_0004, 32'h88, 1));
    vecs.push_back(mk(2'b10, 2'b10, 32'h0, 32'h99, 2'b10, 1, 32'hB003_0008, 32'h99, 1));
    vecs.push_back(mk(2'b11, 2'b11, 32'hAA, 32'hBB, 2'b01, 1, 32'hB002_0000, 32'hAA, 1));
    vecs.push_back(mk(2'b10, 2'b10, 32'hAA, 32'hBB, 2'b10, 1, 32'hB003_0000, 32'hBB, 1));
    vecs.push_back(mk(2'b00, 2'b00, 32'h0,  32'h0,  2'b00, 0, 32'hB003_0000, 32'hBB, 0));

    for (int i = 0; i < vecs.size(); i++) begin
      req_valid = vecs[i].valid;
      req_last  = vecs[i].last;
      req_data  = {vecs[i].d1, vecs[i].d0};
      @(negedge clk);
      check($sformatf("v%0d_ready", i), {30'd0, req_ready}, {30'd0, vecs[i].ready});
      @(posedge clk);
      #1;
      check($sformatf("v%0d_we", i), {28'd0, write_enable}, vecs[i].we ? 32'hF : 32'h0);
      check($sformatf("v%0d_addr", i), bram_addr, vecs[i].addr);
      check($sformatf("v%0d_data", i), bram_data, vecs[i].data);
      check($sformatf("v%0d_busy", i), {31'd0, busy}, {31'd0, vecs[i].busy});
      check($sformatf("v%0d_ovf", i), {30'd0, overflow}, 32'h0);
    end

    // Wrap with a 4-word region: requester 1 streams without last.
    drive(2'b10, 2'b00, 0, 32'h1, 1'b0);
    check("wrap1_addr", w_bram_addr, 32'hB003_0000);
    check("wrap1_ovf", {30'd0, w_overflow}, 32'h0);
    drive(2'b10, 2'b00, 0, 32'h2, 1'b0);
    check("wrap2_addr", w_bram_addr, 32'hB003_0004);
    drive(2'b10, 2'b00, 0, 32'h3, 1'b0);
    check("wrap3_addr", w_bram_addr, 32'hB003_0008);
    check("wrap3_ovf", {30'd0, w_overflow}, 32'h0);
    drive(2'b10, 2'b00, 0, 32'h4, 1'b0);
    check("wrap4_addr", w_bram_addr, 32'hB003_000C);
    check("wrap4_ovf", {30'd0, w_overflow}, 32'h2);
    drive(2'b10, 2'b00, 0, 32'h5, 1'b0);
    check("wrap5_addr", w_bram_addr, 32'hB003_0000);
    check("wrap5_data", w_bram_data, 32'h5);
    check("wrap5_ovf", {30'd0, w_overflow}, 32'h2);
    check("big_no_ovf", {30'd0, overflow}, 32'h0);
    drive(2'b00, 2'b00, 0, 0, 1'b0);
    check("ovf_sticky", {30'd0, w_overflow}, 32'h2);
    check("wrap_idle_we", {28'd0, w_write_enable}, 32'h0);
    drive(2'b00, 2'b00, 0, 0, 1'b1);
    check("ovf_cleared", {30'd0, w_overflow}, 32'h0);
    drive(2'b10, 2'b00, 0, 32'h6, 1'b0);
    check("wrap6_addr", w_bram_addr, 32'hB003_0004);
    drive(2'b10, 2'b00, 0, 32'h7, 1'b0);
    check("wrap7_addr", w_bram_addr, 32'hB003_0008);
    drive(2'b10, 2'b00, 0, 32'h8, 1'b1);
    check("wrap8_addr", w_bram_addr, 32'hB003_000C);
    check("set_beats_clear", {30'd0, w_overflow}, 32'h2);
    drive(2'b00, 2'b00, 0, 0, 1'b0);
    check("ovf_after_tie", {30'd0, w_overflow}, 32'h2);

    // Reset mid-job: word 1 accepted, reset lands before word 2's accept edge.
    reset = 1'b0;
    @(posedge clk);
    #1;
    reset = 1'b1;
    check("rst2_ovf", {30'd0, w_overflow}, 32'h0);
    drive(2'b01, 2'b00, 32'h1, 0, 1'b0);
    check("mid1_addr", bram_addr, 32'hB002_0000);
    check("mid1_busy", {31'd0, busy}, 32'h1);
    req_data = {32'h0, 32'h2};
    @(negedge clk);
    check("mid2_ready", {30'd0, req_ready}, 32'h1);
    reset = 1'b0;
    #1;
    check("mid_rst_ready", {30'd0, req_ready}, 32'h0);
    @(posedge clk);
    #1;
    check("mid_no_we", {28'd0, write_enable}, 32'h0);
    check("mid_busy", {31'd0, busy}, 32'h0);
    reset = 1'b1;
    drive(2'b01, 2'b00, 32'h3, 0, 1'b0);
    check("mid3_we", {28'd0, write_enable}, 32'hF);
    check("mid3_addr", bram_addr, 32'hB002_0000);
    check("mid3_data", bram_data, 32'h3);
    drive(2'b00, 2'b00, 0, 0, 1'b0);
    check("mid_idle_we", {28'd0, write_enable}, 32'h0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
